bird_physics_engine: RTL

//  Parametrised per-frame vertical physics for the bird sprite: gravity, flap impulse,

---
 rtl/bird_physics_engine.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bird_physics_engine.sv
// Per-frame vertical physics for the bird sprite.
// Gravity, flap impulse, terminal velocity, ceiling clamp and ground death.
module bird_physics_engine #(
  parameter int Y_WIDTH  = 8,
  parameter int VY_WIDTH = 8,
  parameter int Y_START  = 60,
  parameter int GRAVITY  = 1,
  parameter int JUMP_VY  = 10,
  parameter int VY_MAX   = 4,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 112
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                tick,
  input  logic                flap,
  output logic [Y_WIDTH-1:0]  bird_y,
  output logic [VY_WIDTH-1:0] bird_vy,
  output logic                update_done,
  output logic                hit_ceiling,
  output logic                dead,
  output logic                tick_overrun
);

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, UPD_VY, UPD_Y, CHECK, DEAD
  } state_t;

  localparam logic signed [VY_WIDTH:0] GRAV_W =
    (VY_WIDTH+1)'(GRAVITY);
  localparam logic signed [VY_WIDTH:0] VMAX_W =
    (VY_WIDTH+1)'(VY_MAX);
  localparam logic [VY_WIDTH-1:0] VY_JUMP =
    VY_WIDTH'(-JUMP_VY);
  localparam logic signed [Y_WIDTH+1:0] YMIN_W =
    (Y_WIDTH+2)'(Y_MIN);
  localparam logic signed [Y_WIDTH+1:0] YMAX_W =
    (Y_WIDTH+2)'(Y_MAX);
  localparam logic [Y_WIDTH-1:0] Y_START_V = Y_WIDTH'(Y_START);
  localparam logic [Y_WIDTH-1:0] Y_MIN_V   = Y_WIDTH'(Y_MIN);
  localparam logic [Y_WIDTH-1:0] Y_MAX_V   = Y_WIDTH'(Y_MAX);

  state_t state;
  logic   flap_q;
  logic   ground_q;

  logic signed [VY_WIDTH:0]  vy_sum;
  logic signed [Y_WIDTH+1:0] y_next;
  logic                      at_ceil;
  logic                      at_ground;

  always_comb begin
    vy_sum = $signed({bird_vy[VY_WIDTH-1], bird_vy}) + GRAV_W;
    y_next = $signed({2'b00, bird_y})
           + $signed({{(Y_WIDTH+2-VY_WIDTH){bird_vy[VY_WIDTH-1]}},
                      bird_vy});
    at_ceil   = y_next < YMIN_W;
    at_ground = y_next >= YMAX_W;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      bird_y       <= Y_START_V;
      bird_vy      <= '0;
      flap_q       <= 1'b0;
      ground_q     <= 1'b0;
      update_done  <= 1'b0;
      hit_ceiling  <= 1'b0;
      dead         <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      update_done <= 1'b0;
      hit_ceiling <= 1'b0;
      if (start) begin
        // start outranks tick; any step in flight is dropped
        state        <= WAIT_TICK;
        bird_y       <= Y_START_V;
        bird_vy      <= '0;
        flap_q       <= 1'b0;
        ground_q     <= 1'b0;
        dead         <= 1'b0;
        tick_overrun <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          WAIT_TICK: begin
            flap_q <= flap_q | flap;
            if (tick) state <= UPD_VY;
          end
          UPD_VY: begin
            if (tick) tick_overrun <= 1'b1;
            // a flap arriving on the consume cycle is used now
            if (flap_q | flap) begin
              bird_vy <= VY_JUMP;
            end else if (vy_sum > VMAX_W) begin
              bird_vy <= VMAX_W[VY_WIDTH-1:0];
            end else begin
              bird_vy <= vy_sum[VY_WIDTH-1:0];
            end
            flap_q <= 1'b0;
            state  <= UPD_Y;
          end
          UPD_Y: begin
            if (tick) tick_overrun <= 1'b1;
            flap_q <= flap_q | flap;
            if (at_ceil) begin
              bird_y  <= Y_MIN_V;
              bird_vy <= '0;
            end else if (at_ground) begin
              bird_y  <= Y_MAX_V;
            end else begin
              bird_y  <= y_next[Y_WIDTH-1:0];
            end
            ground_q    <= ~at_ceil & at_ground;
            hit_ceiling <= at_ceil;
            update_done <= 1'b1;
            state       <= CHECK;
          end
          CHECK: begin
            if (tick) tick_overrun <= 1'b1;
            flap_q <= flap_q | flap;
            dead   <= ground_q;
            state  <= ground_q ? DEAD : WAIT_TICK;
          end
          DEAD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
